// File: rtl/frightened_timer.sv
// Frightened-mode timer: power-pellet countdown in frame ticks, end warning and ghost-eating combo score.
// Optional FRIGHT_PAUSE_EN: when defined, i_pause freezes the countdown; otherwise i_pause is ignored.
module frightened_timer #(
    parameter int FRIGHT_FRAMES = 360,
    parameter int WARN_FRAMES   = 120
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_tick,
    input  logic        i_power_pellet_eaten,
    input  logic        i_ghost_eaten,
    input  logic        i_pause,
    output logic        o_frightened,
    output logic        o_frightened_mode_come_to_end,
    output logic        o_fright_start,
    output logic        o_fright_end,
    output logic [9:0]  o_frames_left,
    output logic [10:0] o_eat_score,
    output logic        o_eat_score_valid,
    output logic [1:0]  o_state
);

    // Handshake: all event inputs are single-cycle pulses sampled on the rising edge;
    // every output is registered and reflects those pulses exactly one cycle later.
    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_ACTIVE = 2'd1,
        F_WARN   = 2'd2
    } state_t;

    localparam logic [9:0]  FRIGHT_LOAD = 10'(FRIGHT_FRAMES);
    localparam logic [9:0]  WARN_LEVEL  = 10'(WARN_FRAMES);
    localparam logic [10:0] BASE_SCORE  = 11'd200;

    state_t      state, state_n;
    logic [9:0]  count_n, count_dec;
    logic [1:0]  combo, combo_n;
    logic [10:0] score_n;
    logic        start_n, end_n, valid_n;
    logic        frozen, active;

`ifdef FRIGHT_PAUSE_EN
    assign frozen = i_pause;
`else
    logic unused_pause;
    assign unused_pause = i_pause;
    assign frozen       = 1'b0;
`endif

    assign active    = (state != F_IDLE);
    assign count_dec = o_frames_left - 10'd1;
    assign o_state   = state;

    always_comb begin
        state_n = state;
        count_n = o_frames_left;
        combo_n = combo;
        score_n = o_eat_score;
        start_n = 1'b0;
        end_n   = 1'b0;
        valid_n = 1'b0;

        // The ghost is scored at the combo index in force before any reload or expiry this cycle.
        if (i_ghost_eaten && active) begin
            score_n = BASE_SCORE << combo;
            valid_n = 1'b1;
            if (combo != 2'd3) combo_n = combo + 2'd1;
        end

        if (i_frame_tick && active && !frozen) begin
            count_n = count_dec;
            if (count_dec == 10'd0) begin
                state_n = F_IDLE;
                end_n   = 1'b1;
                combo_n = 2'd0;
            end else if (count_dec <= WARN_LEVEL) begin
                state_n = F_WARN;
            end else begin
                state_n = F_ACTIVE;
            end
        end

        // A reload wins over a same-cycle expiry.
        if (i_power_pellet_eaten) begin
            state_n = F_ACTIVE;
            count_n = FRIGHT_LOAD;
            combo_n = 2'd0;
            start_n = 1'b1;
            end_n   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state                         <= F_IDLE;
            combo                         <= 2'd0;
            o_frames_left                 <= 10'd0;
            o_eat_score                   <= 11'd0;
            o_eat_score_valid             <= 1'b0;
            o_fright_start                <= 1'b0;
            o_fright_end                  <= 1'b0;
            o_frightened                  <= 1'b0;
            o_frightened_mode_come_to_end <= 1'b0;
        end else begin
            state                         <= state_n;
            combo                         <= combo_n;
            o_frames_left                 <= count_n;
            o_eat_score                   <= score_n;
            o_eat_score_valid             <= valid_n;
            o_fright_start                <= start_n;
            o_fright_end                  <= end_n;
            o_frightened                  <= (state_n != F_IDLE);
            o_frightened_mode_come_to_end <= (state_n == F_WARN);
        end
    end

endmodule

// File: doc/frightened_timer.md
FRIGHTENED_TIMER -- requirements
Module: frightened_timer

Interface
REQ-001 SHALL have parameter FRIGHT_FRAMES, default 360, frightened duration in frame ticks (1..1023).
REQ-002 SHALL have parameter WARN_FRAMES, default 120, remaining-frame threshold for end warning; constraint 0 < WARN_FRAMES < FRIGHT_FRAMES.
REQ-003 SHALL have port i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_frame_tick  input  1  one-cycle pulse per video frame.
REQ-006 SHALL have port i_power_pellet_eaten  input  1  one-cycle pulse, Pac-Man ate a power pellet.
REQ-007 SHALL have port i_ghost_eaten  input  1  one-cycle pulse, Pac-Man collided with a frightened ghost.
REQ-008 SHALL have port i_pause  input  1  level, game paused.
REQ-009 SHALL have port o_frightened  output  1  level, frightened mode active (drives ghost FSMs into G_FRIGHTENED).
REQ-010 SHALL have port o_frightened_mode_come_to_end  output  1  level, warning phase; feeds ghost pose selection (flashing sprites).
REQ-011 SHALL have port o_fright_start  output  1  one-cycle pulse on each (re)load.
REQ-012 SHALL have port o_fright_end  output  1  one-cycle pulse on natural expiry.
REQ-013 SHALL have port o_frames_left  output  10  remaining frame ticks.
REQ-014 SHALL have port o_eat_score  output  11  points for latest ghost eaten (200/400/800/1600).
REQ-015 SHALL have port o_eat_score_valid  output  1  one-cycle pulse qualifying o_eat_score.

Function
REQ-016 SHALL implement FSM states F_IDLE, F_ACTIVE, F_WARN; all outputs registered.
REQ-017 SHALL, on i_power_pellet_eaten in any state, next cycle: counter=FRIGHT_FRAMES, state=F_ACTIVE, o_fright_start=1, combo index=0 (latency 1 cycle).
REQ-018 SHALL, in F_ACTIVE/F_WARN on i_frame_tick (not paused), decrement counter by 1.
REQ-019 SHALL enter F_WARN when updated counter <= WARN_FRAMES and > 0.
REQ-020 SHALL, when a tick decrements counter from 1 to 0, enter F_IDLE, pulse o_fright_end one cycle, reset combo index.
REQ-021 SHALL drive o_frightened=1 in F_ACTIVE and F_WARN; o_frightened_mode_come_to_end=1 only in F_WARN.
REQ-022 SHALL ignore i_frame_tick in F_IDLE; counter holds 0.
REQ-023 SHALL, on i_ghost_eaten in F_ACTIVE/F_WARN, next cycle output o_eat_score=200<<combo index with o_eat_score_valid=1, then increment combo index saturating at 3 (1600).
REQ-024 SHALL ignore i_ghost_eaten in F_IDLE (no valid pulse, o_eat_score holds).
REQ-025 SHALL, on simultaneous i_ghost_eaten and i_power_pellet_eaten while active, score the ghost at the pre-reload combo index, then apply reload with combo index 0.
REQ-026 SHALL, on simultaneous i_power_pellet_eaten and a tick reaching 0, give reload priority: no o_fright_end, counter=FRIGHT_FRAMES.
REQ-027 SHALL, on simultaneous i_power_pellet_eaten and i_ghost_eaten in F_IDLE, start frightened mode and not score the ghost.
REQ-028 SHALL keep o_frames_left equal to internal counter.

Reset
REQ-029 SHALL, while i_rst_n=0 at a clock edge, set state F_IDLE, counter 0, combo 0, all 1-bit outputs 0, o_eat_score 0; reset overrides all inputs including a concurrent pellet pulse.
REQ-030 SHALL, on reset mid-frightened, produce no o_fright_end pulse.

Configuration
REQ-031 SHALL, with FRIGHT_PAUSE_EN defined, freeze counter and state while i_pause=1 (ticks ignored; pellet and ghost events still processed).
REQ-032 SHALL, without FRIGHT_PAUSE_EN, ignore i_pause entirely; port remains present.

Verification (FRIGHT_FRAMES=8, WARN_FRAMES=3)
REQ-033 SHALL cover: pellet pulse -> next cycle o_frightened=1, o_fright_start=1, o_frames_left=8; after 5 ticks o_frames_left=3, come_to_end=1; after 8 ticks o_frightened=0, one o_fright_end pulse.
REQ-034 SHALL cover: pellet then 5 ghost_eaten pulses -> o_eat_score 200,400,800,1600,1600 each with one valid pulse.
REQ-035 SHALL cover: pellet at o_frames_left=1 coincident with tick -> o_frames_left=8, no o_fright_end, combo restarts at 200.
REQ-036 SHALL cover: ghost_eaten in F_IDLE -> no o_eat_score_valid; ghost_eaten+pellet while active at combo 2 -> score 800, next ghost scores 200.
REQ-037 SHALL cover: FRIGHT_PAUSE_EN defined, i_pause=1 for 4 ticks at o_frames_left=6 -> stays 6; undefined -> reaches 2.
REQ-038 SHALL cover: i_rst_n=0 during F_WARN -> next cycle all outputs 0, state F_IDLE, no o_fright_end.
